bin2gray_counter: RTL and testbench
===================================

# bin2gray_counter

Synchronous binary-to-Gray encoding counter: an internal binary count is stepped up or down and presented at its outputs alongside its registered Gray-code image. It is the encoding end of the Gray-code path: grayTobinary decodes what this block produces. It sources Gray-coded pointers and position codes, with a single-bit-change guarantee on every count step.

## Interface

Parameters:
- WIDTH, default 3: width of the binary count and of the Gray code (≥ 2).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when a step occurs.
- load  input  1  load request; takes `load_bin` this cycle.
- load_bin  input  WIDTH  binary value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of `bin_out`.
- flip  output  WIDTH  registered mask of the Gray bits changed by the last update.
- wrap  output  1  registered one-cycle pulse: the last update crossed the terminal value.

## Operation

- Gray rule: `gray = bin ^ (bin >> 1)`. MSB of gray equals MSB of bin.
- Priority at each rising edge: `rst` > `load` > `en` > hold.
- rst:
  - `bin_out`, `gray_out`, `flip` = 0.
  - `wrap` = 0.
- load (`rst` low):
  - `bin_out` = `load_bin`.
  - `gray_out` = Gray(`load_bin`).
  - `flip` = old `gray_out` ^ new `gray_out`. This may be multi-bit or zero.
  - `wrap` = 0.
  - `en` and `up` are ignored this cycle.
- step (`en` high, `load` low):
  - `bin_out` = `bin_out` ± 1, modulo 2^WIDTH.
  - `gray_out` updated on the same edge.
  - `flip` = exactly one set bit.
- wrap conditions:
  - Up step from all-ones to 0 → `wrap` = 1.
  - Down step from 0 to all-ones → `wrap` = 1.
  - Every other step → `wrap` = 0.
- hold (`en` low, `load` low):
  - `bin_out` and `gray_out` unchanged.
  - `flip` = 0.
  - `wrap` = 0.
- No combinational path from any input to any output.
- Arithmetic is WIDTH-bit unsigned. Overflow and underflow are discarded; `wrap` is the only indication.

## Timing

- Latency: an input sampled at edge N is visible on all outputs immediately after edge N. `bin_out`, `gray_out`, `flip` and `wrap` always refer to the same update.
- `wrap` and `flip` are single-cycle. They clear on the next edge unless another step or load re-asserts them.
- Reset mid-count: the edge with `rst` high forces all outputs to 0, whatever `en` and `load` are. Counting resumes from 0 on the first edge with `rst` low and `en` high.
- Continuous `en`: one step per cycle, no bubbles.
- Direction change: takes effect on the very step in which `up` is sampled.
- Load of the current value: outputs unchanged, `flip` = 0, `wrap` = 0.

## Test plan

1. Reset, then WIDTH=3, `up`=1, `en`=1 for 8 cycles.
   - `gray_out` = 001, 011, 010, 110, 111, 101, 100, 000.
   - `flip` one-hot every cycle.
   - `wrap` = 1 only on the 000 cycle, with `flip` = 100.
2. From reset, `up`=0, `en`=1 for 1 cycle.
   - `bin_out` = 111, `gray_out` = 100, `flip` = 100, `wrap` = 1.
   - Next down step: `bin_out` = 110, `gray_out` = 101, `flip` = 001, `wrap` = 0.
3. `load`=1 with `load_bin`=101 and `en`=1, `up`=1, starting from `bin_out`=010.
   - `bin_out` = 101, `gray_out` = 111, `flip` = 011 ^ 111 = 100, `wrap` = 0.
   - Load wins over step.
4. `en` low for 3 cycles at `bin_out`=100.
   - `gray_out` holds 110, `flip` = 000, `wrap` = 0.
5. `rst` asserted together with `load` and `en` at `bin_out`=111.
   - Next cycle: all outputs 0.
   - Release `rst` with `en`=1, `up`=1: `bin_out` = 001, `gray_out` = 001.
6. Random `en`/`up`/`load` for 10k cycles, WIDTH=3 and WIDTH=8.
   - Feed `gray_out` through grayTobinary (WIDTH=3); its output must equal `bin_out` every cycle.
   - Every step cycle has `popcount(flip)` = 1.

Source files
------------

// File: rtl/bin2gray_if.sv
// Control and result bundle for the binary/Gray counter.
// The master drives the count controls and the slave returns the registered count, Gray image and update flags.
interface bin2gray_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] flip;
    logic             wrap;

    modport master (
        output en, up, load, load_bin,
        input  bin_out, gray_out, flip, wrap
    );

    modport slave (
        input  en, up, load, load_bin,
        output bin_out, gray_out, flip, wrap
    );
endinterface

// File: rtl/bin2gray_counter.sv
// Up/down binary counter with a registered Gray-code image, a changed-bit mask and a wrap pulse.
// Every output comes from a register, so nothing passes combinationally from an input to an output.
module bin2gray_counter #(
    parameter int WIDTH = 3
) (
    input  logic      clk,
    input  logic      rst,
    bin2gray_if.slave bus
);
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1'b1);

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic [WIDTH-1:0] flip_r;
    logic             wrap_r;

    logic [WIDTH-1:0] bin_next_s;
    logic [WIDTH-1:0] gray_next_s;
    logic             wrap_next_s;

    // Next-state selection: load beats step beats hold; wrap flags a terminal crossing.
    always_comb begin
        bin_next_s  = bin_r;
        wrap_next_s = 1'b0;
        if (bus.load) begin
            bin_next_s = bus.load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                bin_next_s  = bin_r + ONE_C;
                wrap_next_s = &bin_r;
            end else begin
                bin_next_s  = bin_r - ONE_C;
                wrap_next_s = ~|bin_r;
            end
        end else begin
            bin_next_s = bin_r;
        end
        gray_next_s = to_gray(bin_next_s);
    end

    // State and output registers; a hold gives a zero flip mask because old and new Gray codes match.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= {WIDTH{1'b0}};
            gray_r <= {WIDTH{1'b0}};
            flip_r <= {WIDTH{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_next_s;
            gray_r <= gray_next_s;
            flip_r <= gray_r ^ gray_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign bus.bin_out  = bin_r;
    assign bus.gray_out = gray_r;
    assign bus.flip     = flip_r;
    assign bus.wrap     = wrap_r;
endmodule

// File: tb/tb_bin2gray_counter.sv
// Self-checking bench for bin2gray_counter: directed scenarios at WIDTH=3, then random traffic
// at WIDTH=3 and WIDTH=8 against an integer reference model and a Gray-to-binary decode.
module tb_bin2gray_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bin2gray_if #(.WIDTH(3)) if3 ();
    bin2gray_if #(.WIDTH(8)) if8 ();

    bin2gray_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    bin2gray_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int gray_decode(input int w, input int g);
        int acc = 0;
        for (int i = w - 1; i >= 0; i--)
            acc = acc | ((((acc >> (i + 1)) ^ (g >> i)) & 1) << i);
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input bit r, input bit ld, input int lb, input bit e, input bit u);
        rst          = r;
        if3.load     = ld;
        if3.load_bin = 3'(lb);
        if3.en       = e;
        if3.up       = u;
    endtask

    task automatic test_reset();
        drive3(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== 10'd0) begin
            failures++;
            $display("FAIL reset: got bin=%b gray=%b flip=%b wrap=%b, want all zero",
                     if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
        end
    endtask

    task automatic test_count_up();
        int exp_gray [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
        drive3(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        drive3(1'b0, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (int'(if3.gray_out) !== exp_gray[i]) begin
                failures++;
                $display("FAIL up_gray[%0d]: got %b want %0d", i, if3.gray_out, exp_gray[i]);
            end
            checks++;
            if (!$onehot(if3.flip)) begin
                failures++;
                $display("FAIL up_flip_onehot[%0d]: got %b want one-hot", i, if3.flip);
            end
            checks++;
            if (if3.wrap !== (i == 7)) begin
                failures++;
                $display("FAIL up_wrap[%0d]: got %b want %b", i, if3.wrap, (i == 7));
            end
        end
        checks++;
        if (if3.flip !== 3'b100) begin
            failures++;
            $display("FAIL up_wrap_flip: got %b want 100", if3.flip);
        end
    endtask

    task automatic test_count_down();
        drive3(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        drive3(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== {3'b111, 3'b100, 3'b100, 1'b1}) begin
            failures++;
            $display("FAIL down_underflow: got bin=%b gray=%b flip=%b wrap=%b, want 111 100 100 1",
                     if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
        end
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== {3'b110, 3'b101, 3'b001, 1'b0}) begin
            failures++;
            $display("FAIL down_step: got bin=%b gray=%b flip=%b wrap=%b, want 110 101 001 0",
                     if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
        end
    endtask

    task automatic test_load_priority();
        drive3(1'b0, 1'b1, 2, 1'b0, 1'b0);
        tick();
        drive3(1'b0, 1'b1, 5, 1'b1, 1'b1);
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== {3'b101, 3'b111, 3'b100, 1'b0}) begin
            failures++;
            $display("FAIL load_over_step: got bin=%b gray=%b flip=%b wrap=%b, want 101 111 100 0",
                     if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
        end
        // Reloading the current value leaves the count alone and flags nothing.
        drive3(1'b0, 1'b1, 5, 1'b1, 1'b0);
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== {3'b101, 3'b111, 3'b000, 1'b0}) begin
            failures++;
            $display("FAIL load_same: got bin=%b gray=%b flip=%b wrap=%b, want 101 111 000 0",
                     if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
        end
    endtask

    task automatic test_hold();
        drive3(1'b0, 1'b1, 4, 1'b0, 1'b0);
        tick();
        drive3(1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== {3'b100, 3'b110, 3'b000, 1'b0}) begin
                failures++;
                $display("FAIL hold[%0d]: got bin=%b gray=%b flip=%b wrap=%b, want 100 110 000 0",
                         i, if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        drive3(1'b0, 1'b1, 7, 1'b0, 1'b0);
        tick();
        drive3(1'b1, 1'b1, 3, 1'b1, 1'b1);
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out, if3.flip, if3.wrap} !== 10'd0) begin
            failures++;
            $display("FAIL reset_priority: got bin=%b gray=%b flip=%b wrap=%b, want all zero",
                     if3.bin_out, if3.gray_out, if3.flip, if3.wrap);
        end
        drive3(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        checks++;
        if ({if3.bin_out, if3.gray_out} !== {3'b001, 3'b001}) begin
            failures++;
            $display("FAIL reset_resume: got bin=%b gray=%b, want 001 001", if3.bin_out, if3.gray_out);
        end
    endtask

    task automatic test_random();
        int  m3 = 0;
        int  m8 = 0;
        int  w [2] = '{3, 8};
        int  cur [2];
        int  nxt [2];
        int  got_bin [2];
        int  got_gray [2];
        int  got_flip [2];
        bit  got_wrap [2];
        bit  ld [2];
        bit  en [2];
        bit  up [2];
        int  lb [2];
        bit  r;
        bit  exp_wrap;
        int  max;
        drive3(1'b1, 1'b0, 0, 1'b0, 1'b0);
        if8.load = 1'b0; if8.en = 1'b0; if8.up = 1'b0; if8.load_bin = 8'd0;
        tick();
        for (int c = 0; c < 10000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 2; k++) begin
                ld[k] = ($urandom_range(0, 15) == 0);
                en[k] = ($urandom_range(0, 3) != 0);
                up[k] = $urandom_range(0, 1);
                lb[k] = $urandom_range(0, (1 << w[k]) - 1);
            end
            rst = r;
            if3.load = ld[0]; if3.en = en[0]; if3.up = up[0]; if3.load_bin = 3'(lb[0]);
            if8.load = ld[1]; if8.en = en[1]; if8.up = up[1]; if8.load_bin = 8'(lb[1]);
            cur[0] = m3;
            cur[1] = m8;
            tick();
            got_bin[0]  = int'(if3.bin_out);  got_bin[1]  = int'(if8.bin_out);
            got_gray[0] = int'(if3.gray_out); got_gray[1] = int'(if8.gray_out);
            got_flip[0] = int'(if3.flip);     got_flip[1] = int'(if8.flip);
            got_wrap[0] = if3.wrap;           got_wrap[1] = if8.wrap;
            for (int k = 0; k < 2; k++) begin
                max = (1 << w[k]) - 1;
                exp_wrap = 1'b0;
                if (r) nxt[k] = 0;
                else if (ld[k]) nxt[k] = lb[k];
                else if (en[k]) begin
                    nxt[k] = up[k] ? (cur[k] + 1) % (max + 1) : (cur[k] + max) % (max + 1);
                    exp_wrap = up[k] ? (cur[k] == max) : (cur[k] == 0);
                end else nxt[k] = cur[k];
                checks++;
                if (got_bin[k] !== nxt[k]) begin
                    failures++;
                    $display("FAIL rand_bin w%0d c%0d: got %0d want %0d", w[k], c, got_bin[k], nxt[k]);
                end
                checks++;
                if (got_gray[k] !== gray_of(nxt[k])) begin
                    failures++;
                    $display("FAIL rand_gray w%0d c%0d: got %0d want %0d", w[k], c, got_gray[k], gray_of(nxt[k]));
                end
                checks++;
                if (gray_decode(w[k], got_gray[k]) !== got_bin[k]) begin
                    failures++;
                    $display("FAIL rand_decode w%0d c%0d: decoded %0d want bin %0d",
                             w[k], c, gray_decode(w[k], got_gray[k]), got_bin[k]);
                end
                checks++;
                if (got_flip[k] !== (r ? 0 : (gray_of(cur[k]) ^ gray_of(nxt[k])))) begin
                    failures++;
                    $display("FAIL rand_flip w%0d c%0d: got %0d want %0d", w[k], c, got_flip[k],
                             r ? 0 : (gray_of(cur[k]) ^ gray_of(nxt[k])));
                end
                checks++;
                if (got_wrap[k] !== exp_wrap) begin
                    failures++;
                    $display("FAIL rand_wrap w%0d c%0d: got %b want %b", w[k], c, got_wrap[k], exp_wrap);
                end
                if (!r && !ld[k] && en[k]) begin
                    checks++;
                    if ($countones(got_flip[k]) != 1) begin
                        failures++;
                        $display("FAIL rand_step_popcount w%0d c%0d: flip %0d has %0d bits, want 1",
                                 w[k], c, got_flip[k], $countones(got_flip[k]));
                    end
                end
            end
            m3 = nxt[0];
            m8 = nxt[1];
        end
        rst = 1'b0;
    endtask

    initial begin
        if3.load = 1'b0; if3.en = 1'b0; if3.up = 1'b0; if3.load_bin = 3'd0;
        if8.load = 1'b0; if8.en = 1'b0; if8.up = 1'b0; if8.load_bin = 8'd0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_priority();
        test_hold();
        test_reset_mid_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
